// File: rtl/npu_pkg.sv
// Shared NPU noun-store definitions: tag encodings, mark/NIL helpers,
// traversal state encoding and error codes.
package npu_pkg;

    // Tag field is the top 3 bits of a noun word; 3'b0?? is an atom.
    localparam logic [2:0] TAG_CELL = 3'b111;
    localparam logic [2:0] TAG_OP   = 3'b101;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_TAG  = 2'b01;
    localparam logic [1:0] ERR_WDOG = 2'b10;

    // Mark bit sits just below the tag.
    function automatic int mark_bit(input int word_w);
        return word_w - 4;
    endfunction

    // NIL is the all-ones address; it never names a storable cell.
    function automatic int unsigned nil_of(input int addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_DEC, S_EMIT, S_DIVE_WR, S_POP_RD, S_POP_WR, S_DONE, S_ERR
    } state_e;

endpackage

// File: rtl/npu_noun_decode.sv
// Combinational split of a noun word into its tag class, mark bit and pointer.
// A cell word whose pointer is NIL is classed as bad, like the illegal tags.
import npu_pkg::*;

module npu_noun_decode #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic [WORD_W-1:0] word,
    output logic              is_atom,
    output logic              is_cell,
    output logic              is_op,
    output logic              is_bad,
    output logic              marked,
    output logic [ADDR_W-1:0] ptr
);
    localparam int              MARK = mark_bit(WORD_W);
    localparam logic [ADDR_W-1:0] NIL = ADDR_W'(nil_of(ADDR_W));

    logic [2:0] tag;
    logic       unused_mid;

    assign tag        = word[WORD_W-1 -: 3];
    assign ptr        = word[ADDR_W-1:0];
    assign marked     = word[MARK];
    assign is_atom    = ~tag[2];
    assign is_op      = (tag == TAG_OP);
    assign is_cell    = (tag == TAG_CELL) && (ptr != NIL);
    assign is_bad     = tag[2] && !is_op && !is_cell;
    assign unused_mid = ^word[MARK-1:ADDR_W];

endmodule

// File: rtl/npu_traverse.sv
// Schorr-Waite pointer-reversal traversal of a binary noun tree. Emits atom
// leaves depth-first, head first, and restores every reversed pointer on the
// way back up (optionally setting the mark bit).
import npu_pkg::*;

module npu_traverse #(
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int STEP_MAX = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] root,
    input  logic              mode_mark,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_tel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              visit_valid,
    input  logic              visit_ready,
    output logic [ADDR_W-1:0] visit_addr,
    output logic              visit_tel,
    output logic [WORD_W-1:0] visit_atom,
    output logic [ADDR_W-1:0] depth
);
    localparam logic [ADDR_W-1:0] NIL = ADDR_W'(nil_of(ADDR_W));
    localparam int SW    = $clog2(STEP_MAX + 1);
    localparam int PAD_W = WORD_W - 4 - ADDR_W;
    localparam int NCELL = 1 << ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   p_q, p_d, b_q, b_d, bb_q, bb_d, depth_q, depth_d;
    logic                dir_q, dir_d, mark_q, mark_d;
    logic [SW-1:0]       step_q, step_d;
    logic [1:0]          err_q, err_d;
    logic [WORD_W-1:0]   v_q, v_d;
    logic [NCELL-1:0]    flag_q, flag_d;

    logic                dec_atom, dec_cell, dec_op, dec_bad, dec_marked;
    logic [ADDR_W-1:0]   dec_ptr;

    npu_noun_decode #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_dec (
        .word    (v_q),
        .is_atom (dec_atom),
        .is_cell (dec_cell),
        .is_op   (dec_op),
        .is_bad  (dec_bad),
        .marked  (dec_marked),
        .ptr     (dec_ptr)
    );

    assign err        = err_q;
    assign depth      = depth_q;
    assign visit_addr = p_q;
    assign visit_tel  = dir_q;
    assign visit_atom = v_q;

    // State and datapath registers; reset leaves memory as it stands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            b_q     <= '0;
            bb_q    <= '0;
            depth_q <= '0;
            dir_q   <= 1'b0;
            mark_q  <= 1'b0;
            step_q  <= '0;
            err_q   <= ERR_OK;
            v_q     <= '0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            b_q     <= b_d;
            bb_q    <= bb_d;
            depth_q <= depth_d;
            dir_q   <= dir_d;
            mark_q  <= mark_d;
            step_q  <= step_d;
            err_q   <= err_d;
            v_q     <= v_d;
            flag_q  <= flag_d;
        end
    end

    // Next-state, memory request and stream outputs of the traversal FSM.
    always_comb begin
        state_d = state_q;  p_d = p_q;      b_d = b_q;        bb_d = bb_q;
        depth_d = depth_q;  dir_d = dir_q;  mark_d = mark_q;  step_d = step_q;
        err_d = err_q;      v_d = v_q;      flag_d = flag_q;
        busy = 1'b0;  done = 1'b0;  visit_valid = 1'b0;
        mem_req = 1'b0;  mem_we = 1'b0;  mem_tel = 1'b0;
        mem_addr = '0;   mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                busy = start;
                if (start) begin
                    p_d = root;  b_d = NIL;  dir_d = 1'b0;  depth_d = '0;
                    step_d = '0; err_d = ERR_OK;  mark_d = mode_mark;
                    state_d = (root == NIL) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                busy = 1'b1;  mem_req = 1'b1;  mem_tel = dir_q;  mem_addr = p_q;
                if (mem_ack) begin
                    v_d = mem_rdata;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                busy = 1'b1;
                if (dec_atom) begin
                    state_d = S_EMIT;
                end else if (dec_cell && dec_marked && mark_q) begin
                    // Already-marked subtree: skip it like a silent leaf.
                    if (!dir_q) begin
                        dir_d = 1'b1;  state_d = S_RD;
                    end else begin
                        state_d = S_POP_RD;
                    end
                end else if (dec_cell) begin
                    state_d = S_DIVE_WR;
                end else if (dec_op || dec_bad) begin
                    err_d = ERR_TAG;  state_d = S_ERR;
                end
            end
            S_EMIT: begin
                busy = 1'b1;  visit_valid = 1'b1;
                if (visit_ready) begin
                    if (!dir_q) begin
                        dir_d = 1'b1;  state_d = S_RD;
                    end else begin
                        state_d = S_POP_RD;
                    end
                end
            end
            S_DIVE_WR: begin
                // Overwrite the child pointer with the back pointer.
                busy = 1'b1;  mem_req = 1'b1;  mem_we = 1'b1;
                mem_tel = dir_q;  mem_addr = p_q;
                mem_wdata = {TAG_CELL, 1'b0, {PAD_W{1'b0}}, b_q};
                if (mem_ack) begin
                    flag_d[p_q] = dir_q;
                    b_d = p_q;  p_d = dec_ptr;  dir_d = 1'b0;
                    depth_d = depth_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_POP_RD: begin
                busy = 1'b1;
                if (b_q == NIL) begin
                    state_d = S_DONE;
                end else begin
                    mem_req = 1'b1;  mem_tel = flag_q[b_q];  mem_addr = b_q;
                    if (mem_ack) begin
                        bb_d = mem_rdata[ADDR_W-1:0];
                        state_d = S_POP_WR;
                    end
                end
            end
            S_POP_WR: begin
                // Put the original child pointer back, marked in mark mode.
                busy = 1'b1;  mem_req = 1'b1;  mem_we = 1'b1;
                mem_tel = flag_q[b_q];  mem_addr = b_q;
                mem_wdata = {TAG_CELL, mark_q, {PAD_W{1'b0}}, p_q};
                if (mem_ack) begin
                    p_d = b_q;  b_d = bb_q;  depth_d = depth_q - 1'b1;
                    if (!flag_q[b_q]) begin
                        dir_d = 1'b1;  state_d = S_RD;
                    end else begin
                        state_d = S_POP_RD;
                    end
                end
            end
            S_DONE, S_ERR: begin
                done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Watchdog: a cyclic graph would otherwise never come home.
        if (mem_req && mem_ack) begin
            step_d = step_q + 1'b1;
            if (step_q == SW'(STEP_MAX - 1)) begin
                err_d = ERR_WDOG;  state_d = S_ERR;
            end
        end
    end

endmodule

// File: tb/tb_npu_traverse.sv
// Directed bench for npu_traverse: a stack-based DFS model predicts the leaf
// stream and final memory; a memory responder and a stream consumer check
// handshakes every cycle.
module tb_npu_traverse;
    localparam int WW = 32, AW = 8, SMAX = 20;
    localparam logic [AW-1:0] NILA = 8'hFF;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, mode_mark = 1'b0;
    logic [AW-1:0] root = '0;
    logic          mem_ack = 1'b0, visit_ready = 1'b0;
    logic [WW-1:0] mem_rdata = '0;
    logic          busy, done, mem_req, mem_we, mem_tel, visit_valid, visit_tel;
    logic [1:0]    err;
    logic [AW-1:0] mem_addr, visit_addr, depth;
    logic [WW-1:0] mem_wdata, visit_atom;

    always #5 clk = ~clk;

    npu_traverse #(.WORD_W(WW), .ADDR_W(AW), .STEP_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .start(start), .root(root), .mode_mark(mode_mark),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_tel(mem_tel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .visit_valid(visit_valid), .visit_ready(visit_ready), .visit_addr(visit_addr),
        .visit_tel(visit_tel), .visit_atom(visit_atom), .depth(depth)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [7:0] a; logic t; logic [31:0] w; } ev_t;

    logic [WW-1:0] hed[256], tel[256], mh[256], mt[256];
    ev_t exp_q[$];
    bit  rand_ack = 0, stall_mode = 0;
    int  wait_cnt = -1, acks = 0;
    logic [AW+1:0] rq_ctl;
    logic [WW-1:0] rq_wdata;

    // Memory responder: 0..3 cycle ack latency, request fields must hold.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!mem_req) begin
            wait_cnt = -1;
        end else begin
            if (wait_cnt < 0) begin
                wait_cnt = rand_ack ? int'($urandom_range(0, 3)) : 0;
                rq_ctl = {mem_we, mem_tel, mem_addr};
                rq_wdata = mem_wdata;
            end else begin
                chk("mem_ctl_stable", 64'({mem_we, mem_tel, mem_addr}), 64'(rq_ctl));
                chk("mem_wdata_stable", 64'(mem_wdata), 64'(rq_wdata));
            end
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                acks++;
                mem_rdata = mem_tel ? tel[mem_addr] : hed[mem_addr];
                if (mem_we) begin
                    if (mem_tel) tel[mem_addr] = mem_wdata;
                    else         hed[mem_addr] = mem_wdata;
                end
                wait_cnt = -1;
            end else begin
                wait_cnt--;
            end
        end
    end

    // Stream consumer/checker: optional 5-cycle stall per event.
    bit  have_ev = 0;
    int  stall = 0;
    ev_t cur, ex;
    always @(negedge clk) begin
        if (!visit_valid) begin
            visit_ready = 1'b0;
            have_ev = 0;
        end else begin
            if (!have_ev) begin
                cur = '{visit_addr, visit_tel, visit_atom};
                have_ev = 1;
                stall = stall_mode ? 5 : 0;
            end else begin
                chk("visit_payload_stable", 64'({visit_addr, visit_tel, visit_atom}), 64'(cur));
            end
            if (stall > 0) begin
                visit_ready = 1'b0;
                stall--;
            end else if (!visit_ready) begin
                visit_ready = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_event actual=%h expected=none", cur);
                end else begin
                    ex = exp_q.pop_front();
                    chk("visit_event", 64'(cur), 64'(ex));
                end
            end
        end
    end

    // Depth-first, head-first walk over the model memory with an explicit
    // stack; returns 1 when a non-atom, non-cell word is reached.
    function automatic bit walk(input logic [7:0] r, input bit mk);
        logic [7:0] cs[$];
        int ss[$];
        logic [7:0] c;
        int s, top;
        logic [31:0] w;
        ev_t e;
        if (r == NILA) return 0;
        cs.push_back(r); ss.push_back(0);
        while (cs.size() > 0) begin
            top = cs.size() - 1;
            c = cs[top]; s = ss[top];
            if (s == 2) begin
                void'(cs.pop_back()); void'(ss.pop_back());
                if (cs.size() > 0) begin
                    top = cs.size() - 1;
                    if (mk) begin
                        if (ss[top] == 1) mt[cs[top]][28] = 1'b1;
                        else              mh[cs[top]][28] = 1'b1;
                    end
                    ss[top] = ss[top] + 1;
                end
            end else begin
                w = (s == 1) ? mt[c] : mh[c];
                if (w[31] == 1'b0) begin
                    e.a = c; e.t = (s == 1); e.w = w;
                    exp_q.push_back(e);
                    ss[top] = ss[top] + 1;
                end else if (w[31:29] == 3'b111 && w[7:0] != NILA) begin
                    if (mk && w[28]) ss[top] = ss[top] + 1;
                    else begin cs.push_back(w[7:0]); ss.push_back(0); end
                end else begin
                    return 1;
                end
            end
        end
        return 0;
    endfunction

    task automatic load_tree();
        for (int i = 0; i < 256; i++) begin hed[i] = '0; tel[i] = '0; end
        hed[0] = 32'hE0000001; tel[0] = 32'h000000FF;
        hed[1] = 32'hE0000002; tel[1] = 32'hE0000003;
        hed[2] = 32'h4;        tel[2] = 32'h5;
        hed[3] = 32'h6;        tel[3] = 32'hE0000004;
        hed[4] = 32'hE;        tel[4] = 32'hF;
    endtask

    task automatic snap_model();
        for (int i = 0; i < 256; i++) begin mh[i] = hed[i]; mt[i] = tel[i]; end
    endtask

    task automatic mem_vs_model(input string name);
        int mism = 0;
        for (int i = 0; i < 256; i++)
            if (hed[i] !== mh[i] || tel[i] !== mt[i]) mism++;
        chk(name, 64'(mism), 64'd0);
    endtask

    // One traversal: pulse start, wait (bounded) for done, check the end.
    task automatic run(input logic [7:0] r, input bit mk, input logic [1:0] exp_err,
                       input int exp_acks, input bit inject);
        int n = 0, a0;
        a0 = acks;
        @(negedge clk); root = r; mode_mark = mk; start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (r != NILA) chk("busy_after_start", 64'(busy), 64'd1);
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (inject && n == 3) begin start = 1'b1; root = 8'h4; end
            if (inject && n == 4) start = 1'b0;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=%0d cycles expected=done", n);
            return;
        end
        if (r == NILA) chk("nil_done_latency", 64'(n), 64'd0);
        chk("err_at_done", 64'(err), 64'(exp_err));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("events_left", 64'(exp_q.size()), 64'd0);
        if (exp_acks >= 0) chk("access_count", 64'(acks - a0), 64'(exp_acks));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("err_held", 64'(err), 64'(exp_err));
    endtask

    initial begin
        bit merr;
        logic [19:0] atoms;
        int n;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_ctl", 64'({busy, done, err, mem_req, mem_we, mem_tel, mem_addr,
                              visit_valid, visit_tel, visit_addr, depth}), 64'd0);
        chk("reset_data", 64'({mem_wdata, visit_atom}), 64'd0);
        reset = 1'b0;

        // Plain walk: atoms 4,5,6,E,F and memory restored bit for bit.
        load_tree(); snap_model();
        merr = walk(8'd1, 1'b0);
        chk("model_err_plain", 64'(merr), 64'd0);
        chk("model_count_plain", 64'(exp_q.size()), 64'd5);
        atoms = {exp_q[0].w[3:0], exp_q[1].w[3:0], exp_q[2].w[3:0], exp_q[3].w[3:0], exp_q[4].w[3:0]};
        chk("model_atoms_plain", 64'(atoms), 64'h456EF);
        run(8'd1, 1'b0, 2'b00, 17, 1'b0);
        mem_vs_model("mem_restored_plain");

        // Mark mode: same atoms, pointers come back with bit 28 set.
        load_tree(); snap_model();
        merr = walk(8'd1, 1'b1);
        run(8'd1, 1'b1, 2'b00, 17, 1'b0);
        mem_vs_model("mem_marked");
        chk("mark_hed1", 64'(hed[1]), 64'hF0000002);
        chk("mark_tel1", 64'(tel[1]), 64'hF0000003);
        chk("mark_tel3", 64'(tel[3]), 64'hF0000004);
        // Second marked run skips everything.
        snap_model();
        merr = walk(8'd1, 1'b1);
        chk("model_count_remark", 64'(exp_q.size()), 64'd0);
        run(8'd1, 1'b1, 2'b00, 2, 1'b0);

        // Stalled consumer, random ack latency, and a start while busy.
        load_tree(); snap_model();
        merr = walk(8'd1, 1'b0);
        stall_mode = 1; rand_ack = 1;
        run(8'd1, 1'b0, 2'b00, 17, 1'b1);
        mem_vs_model("mem_restored_stall");
        stall_mode = 0; rand_ack = 0;

        // Opcode in tel[2]: atom 4, then err 01.
        load_tree(); tel[2] = 32'hA0000000; snap_model();
        merr = walk(8'd1, 1'b0);
        chk("model_err_op", 64'(merr), 64'd1);
        chk("model_count_op", 64'(exp_q.size()), 64'd1);
        run(8'd1, 1'b0, 2'b01, 4, 1'b0);

        // Cycle back to cell 1: the limit trips on access 20, before the
        // walk would reach a NIL back pointer at access 21.
        load_tree(); tel[4] = 32'hE0000001;
        exp_q.delete();
        exp_q.push_back('{8'd2, 1'b0, 32'h4}); exp_q.push_back('{8'd2, 1'b1, 32'h5});
        exp_q.push_back('{8'd3, 1'b0, 32'h6}); exp_q.push_back('{8'd4, 1'b0, 32'hE});
        exp_q.push_back('{8'd2, 1'b0, 32'h4}); exp_q.push_back('{8'd2, 1'b1, 32'h5});
        run(8'd1, 1'b0, 2'b10, SMAX, 1'b0);

        // NIL root: done next cycle, no memory access.
        exp_q.delete();
        run(NILA, 1'b0, 2'b00, 0, 1'b0);

        // Asynchronous reset during the first pointer-reversing write.
        load_tree(); exp_q.delete();
        @(negedge clk); root = 8'd1; mode_mark = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin @(negedge clk); n++; end
        chk("reached_dive_wr", 64'(mem_req && mem_we), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrun_reset_ctl", 64'({busy, done, err, mem_req, mem_we, mem_tel, mem_addr,
                                     visit_valid, visit_tel, visit_addr, depth}), 64'd0);
        chk("midrun_reset_data", 64'({mem_wdata, visit_atom}), 64'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
